// File: rtl/ysyx_210184_mem_arbiter.sv
// Round-robin arbiter merging the fetch (read-only) and data (read/write) ports onto one level-handshake slave port.
// Latency: grant registered one cycle after request; slave completion forwarded same cycle; one release cycle follows.
// Backpressure: a requester holds its enable until its ready pulse; one transaction outstanding at a time.
module ysyx_210184_mem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_r_ena,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_r_data,
    output logic                if_r_ready,
    input  logic                d_r_ena,
    input  logic                d_w_ena,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_w_data,
    input  logic [DATA_W/8-1:0] d_w_mask,
    output logic [DATA_W-1:0]   d_r_data,
    output logic                d_r_ready,
    output logic                d_w_ready,
    output logic                m_r_ena,
    output logic                m_w_ena,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_w_data,
    output logic [DATA_W/8-1:0] m_w_mask,
    input  logic [DATA_W-1:0]   m_r_data,
    input  logic                m_r_ready,
    input  logic                m_w_ready,
    output logic                err_spurious,
    output logic                err_timeout
);
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT_IF,
        S_GRANT_D,
        S_RELEASE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_d;
    logic             lat_r;
    logic             lat_w;
    logic [CNT_W-1:0] wait_cnt;
    logic             comp;
    logic             in_grant;
    logic             grant_if;
    logic             grant_d;

    assign comp     = m_r_ready | m_w_ready;
    assign in_grant = (state == S_GRANT_IF) || (state == S_GRANT_D);

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        case (state)
            S_IDLE: begin
                // On contention the port that did not win last time gets the grant.
                if (if_r_ena && (d_r_ena || d_w_ena)) begin
                    grant_if = last_d;
                    grant_d  = !last_d;
                end else begin
                    grant_if = if_r_ena;
                    grant_d  = d_r_ena || d_w_ena;
                end
                if (grant_if) begin
                    state_nxt = S_GRANT_IF;
                end else if (grant_d) begin
                    state_nxt = S_GRANT_D;
                end
            end
            S_GRANT_IF, S_GRANT_D: begin
                if (comp) begin
                    state_nxt = S_RELEASE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            last_d       <= 1'b1;
            lat_r        <= 1'b0;
            lat_w        <= 1'b0;
            wait_cnt     <= '0;
            err_spurious <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state <= state_nxt;
            // Enables are captured at grant so a requester dropping mid-flight cannot abort the slave access.
            if (grant_if) begin
                lat_r    <= 1'b1;
                lat_w    <= 1'b0;
                wait_cnt <= '0;
            end else if (grant_d) begin
                lat_r    <= d_r_ena;
                lat_w    <= d_w_ena;
                wait_cnt <= '0;
            end
            if (in_grant && comp) begin
                last_d <= (state == S_GRANT_D);
            end
            if (in_grant && !comp) begin
                if (wait_cnt != CNT_MAX) begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
                if ((TIMEOUT_CYC != 0) && ((32'(wait_cnt) + 32'd1) >= 32'(TIMEOUT_CYC))) begin
                    err_timeout <= 1'b1;
                end
            end
            if ((!in_grant && comp) || (m_r_ready && m_w_ready)) begin
                err_spurious <= 1'b1;
            end
        end
    end

    assign m_r_ena = in_grant & lat_r;
    assign m_w_ena = in_grant & lat_w;

    always_comb begin
        m_addr   = '0;
        m_w_data = '0;
        m_w_mask = '0;
        if (state == S_GRANT_IF) begin
            m_addr = if_addr;
        end else if (state == S_GRANT_D) begin
            m_addr   = d_addr;
            m_w_data = d_w_data;
            m_w_mask = d_w_mask;
        end
    end

    assign if_r_ready = (state == S_GRANT_IF) & comp;
    assign d_r_ready  = (state == S_GRANT_D) & comp & lat_r;
    assign d_w_ready  = (state == S_GRANT_D) & comp & lat_w;
    assign if_r_data  = if_r_ready ? m_r_data : '0;
    assign d_r_data   = d_r_ready ? m_r_data : '0;

endmodule

// File: tb/tb_ysyx_210184_mem_arbiter.sv
// Bench for the fetch/data memory arbiter: directed table, hand sequences, randomized round-robin traffic.
`timescale 1ns/1ps
module tb_ysyx_210184_mem_arbiter;
    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_r_ena = 1'b0;
    logic [63:0] if_addr = '0;
    logic [63:0] if_r_data;
    logic        if_r_ready;
    logic        d_r_ena = 1'b0;
    logic        d_w_ena = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_w_data = '0;
    logic [7:0]  d_w_mask = '0;
    logic [63:0] d_r_data;
    logic        d_r_ready;
    logic        d_w_ready;
    logic        m_r_ena;
    logic        m_w_ena;
    logic [63:0] m_addr;
    logic [63:0] m_w_data;
    logic [7:0]  m_w_mask;
    logic [63:0] m_r_data = '0;
    logic        m_r_ready = 1'b0;
    logic        m_w_ready = 1'b0;
    logic        err_spurious;
    logic        err_timeout;

    ysyx_210184_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYC(TMO)) dut (
        .clock(clock), .reset(reset),
        .if_r_ena(if_r_ena), .if_addr(if_addr), .if_r_data(if_r_data), .if_r_ready(if_r_ready),
        .d_r_ena(d_r_ena), .d_w_ena(d_w_ena), .d_addr(d_addr), .d_w_data(d_w_data),
        .d_w_mask(d_w_mask), .d_r_data(d_r_data), .d_r_ready(d_r_ready), .d_w_ready(d_w_ready),
        .m_r_ena(m_r_ena), .m_w_ena(m_w_ena), .m_addr(m_addr), .m_w_data(m_w_data),
        .m_w_mask(m_w_mask), .m_r_data(m_r_data), .m_r_ready(m_r_ready), .m_w_ready(m_w_ready),
        .err_spurious(err_spurious), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    // port codes: 0 = fetch read, 1 = data read, 2 = data write
    // exp = {m_r_ena, m_w_ena, if_r_ready, d_r_ready, d_w_ready}
    typedef struct {
        int          port;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [63:0] rdata;
        int          lat;
        bit          both;
        logic [4:0]  exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit model_last_d = 1'b1;
    bit model_spur = 1'b0;
    bit model_tmo = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] exp_of(input int port);
        case (port)
            0:       return 5'b10_100;
            1:       return 5'b10_010;
            default: return 5'b01_001;
        endcase
    endfunction

    task automatic raise(input int port, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] mask);
        if (port == 0) begin
            if_r_ena = 1'b1;
            if_addr  = addr;
        end else begin
            d_r_ena  = (port == 1);
            d_w_ena  = (port == 2);
            d_addr   = addr;
            d_w_data = wdata;
            d_w_mask = mask;
        end
    endtask

    // Acts as the slave for one transaction; entered at a negedge, returns at the release-cycle negedge.
    task automatic serve(input string tag, input int port, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] mask, input logic [63:0] rdata,
                         input int lat, input bit both, input int exp_wait, input logic [4:0] exp);
        int waitc = 0;
        @(negedge clock);
        while (!(m_r_ena || m_w_ena) && waitc < 20) begin
            @(negedge clock);
            waitc++;
        end
        chk({tag, "_granted"}, 64'(waitc < 20), 64'd1);
        if (exp_wait >= 0) chk({tag, "_grant_lat"}, 64'(waitc), 64'(exp_wait));
        chk({tag, "_ena"}, {m_r_ena, m_w_ena}, exp[4:3]);
        chk({tag, "_addr"}, m_addr, addr);
        if (port == 2) begin
            chk({tag, "_wdata"}, m_w_data, wdata);
            chk({tag, "_mask"}, 64'(m_w_mask), 64'(mask));
        end
        for (int k = 0; k < lat; k++) begin
            chk({tag, "_wait_rdy"}, {if_r_ready, d_r_ready, d_w_ready}, 3'b000);
            chk({tag, "_wait_tmo"}, 64'(err_timeout), 64'(model_tmo || (k >= TMO)));
            chk({tag, "_wait_spur"}, 64'(err_spurious), 64'(model_spur));
            @(negedge clock);
        end
        m_r_data = rdata;
        if (both) begin
            m_r_ready = 1'b1;
            m_w_ready = 1'b1;
        end else if (port == 2) begin
            m_w_ready = 1'b1;
        end else begin
            m_r_ready = 1'b1;
        end
        #1;
        chk({tag, "_rdy"}, {if_r_ready, d_r_ready, d_w_ready}, exp[2:0]);
        if (port == 0) chk({tag, "_if_rdata"}, if_r_data, rdata);
        if (port == 1) chk({tag, "_d_rdata"}, d_r_data, rdata);
        @(posedge clock);
        #1;
        m_r_ready = 1'b0;
        m_w_ready = 1'b0;
        if (port == 0) begin
            if_r_ena = 1'b0;
        end else begin
            d_r_ena = 1'b0;
            d_w_ena = 1'b0;
        end
        model_last_d = (port != 0);
        if (lat >= TMO) model_tmo = 1'b1;
        if (both) model_spur = 1'b1;
        @(negedge clock);
        chk({tag, "_release_gap"}, {m_r_ena, m_w_ena}, 2'b00);
        chk({tag, "_spur_flag"}, 64'(err_spurious), 64'(model_spur));
        chk({tag, "_tmo_flag"}, 64'(err_timeout), 64'(model_tmo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{0, 64'h8000_0000, 64'h0, 8'h00, 64'hDEAD_BEEF_0000_0013, 3, 1'b0, 5'b10_100};
        tbl[1] = '{2, 64'h0200_4000, 64'h55, 8'h0F, 64'h1234, 1, 1'b0, 5'b01_001};
        tbl[2] = '{1, 64'h0200_0008, 64'h0, 8'h00, 64'hCAFE_F00D_1122_3344, 0, 1'b0, 5'b10_010};
        tbl[3] = '{0, 64'h8000_0010, 64'h0, 8'h00, 64'h0000_0000_0000_0093, 0, 1'b0, 5'b10_100};
        tbl[4] = '{2, 64'h8000_1000, 64'hFFFF_0000_FFFF_0000, 8'hFF, 64'h0, 2, 1'b1, 5'b01_001};
        tbl[5] = '{0, 64'h8000_2000, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 10, 1'b0, 5'b10_100};

        // Reset values
        @(negedge clock);
        chk("rst_ctrl", {m_r_ena, m_w_ena, if_r_ready, d_r_ready, d_w_ready, err_spurious, err_timeout}, 7'b0);
        chk("rst_addr", m_addr, 64'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ctrl", {m_r_ena, m_w_ena, err_spurious, err_timeout}, 4'b0);

        // Simultaneous requests from reset: IF, D, then IF again
        raise(0, 64'h8000_0100, 64'h0, 8'h0);
        raise(1, 64'h0200_0100, 64'h0, 8'h0);
        serve("rr1_if", 0, 64'h8000_0100, 64'h0, 8'h0, 64'h11, 1, 1'b0, 0, exp_of(0));
        serve("rr2_d", 1, 64'h0200_0100, 64'h0, 8'h0, 64'h22, 1, 1'b0, 1, exp_of(1));
        raise(0, 64'h8000_0200, 64'h0, 8'h0);
        raise(1, 64'h0200_0200, 64'h0, 8'h0);
        serve("rr3_if", 0, 64'h8000_0200, 64'h0, 8'h0, 64'h33, 0, 1'b0, 1, exp_of(0));
        serve("rr4_d", 1, 64'h0200_0200, 64'h0, 8'h0, 64'h44, 0, 1'b0, 1, exp_of(1));

        // Ready while idle is ignored and flagged
        @(negedge clock);
        m_r_ready = 1'b1;
        m_r_data  = 64'hBAD;
        #1;
        chk("spur_no_rdy", {if_r_ready, d_r_ready, d_w_ready}, 3'b000);
        @(posedge clock);
        #1;
        m_r_ready = 1'b0;
        @(negedge clock);
        chk("spur_set", 64'(err_spurious), 64'd1);
        chk("spur_no_grant", {m_r_ena, m_w_ena}, 2'b00);
        repeat (3) @(negedge clock);
        chk("spur_sticky", 64'(err_spurious), 64'd1);
        model_spur = 1'b1;

        // Directed table (each entry starts from idle)
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            raise(tbl[i].port, tbl[i].addr, tbl[i].wdata, tbl[i].mask);
            serve($sformatf("tbl%0d", i), tbl[i].port, tbl[i].addr, tbl[i].wdata, tbl[i].mask,
                  tbl[i].rdata, tbl[i].lat, tbl[i].both, 0, tbl[i].exp);
        end

        // Randomized traffic checked against round-robin ordering rules
        for (int r = 0; r < 40; r++) begin
            int          mode;
            int          dport;
            int          first;
            int          second;
            logic [63:0] ia;
            logic [63:0] da;
            logic [63:0] wd;
            logic [7:0]  mk;
            mode  = $urandom_range(0, 2);
            dport = $urandom_range(1, 2);
            ia    = {$urandom, $urandom};
            da    = ia ^ 64'h8;
            wd    = {$urandom, $urandom};
            mk    = 8'($urandom);
            @(negedge clock);
            if (mode != 1) raise(0, ia, 64'h0, 8'h0);
            if (mode != 0) raise(dport, da, wd, mk);
            if (mode == 0) begin
                first = 0;
            end else if (mode == 1) begin
                first = dport;
            end else begin
                first = model_last_d ? 0 : dport;
            end
            second = (first == 0) ? dport : 0;
            serve($sformatf("rnd%0d_a", r), first, (first == 0) ? ia : da, wd, mk,
                  {$urandom, $urandom}, $urandom_range(0, 6), 1'b0, 0, exp_of(first));
            if (mode == 2) begin
                serve($sformatf("rnd%0d_b", r), second, (second == 0) ? ia : da, wd, mk,
                      {$urandom, $urandom}, $urandom_range(0, 6), 1'b0, 1, exp_of(second));
            end
        end

        // Reset in the middle of a data-port grant
        @(negedge clock);
        raise(2, 64'h0200_4008, 64'h77, 8'hF0);
        @(negedge clock);
        chk("rmg_granted", 64'(m_w_ena), 64'd1);
        #1;
        reset     = 1'b1;
        m_w_ready = 1'b1;
        d_w_ena   = 1'b0;
        #1;
        chk("rmg_ctrl", {m_r_ena, m_w_ena, if_r_ready, d_r_ready, d_w_ready, err_spurious, err_timeout}, 7'b0);
        chk("rmg_addr", m_addr, 64'h0);
        @(negedge clock);
        reset        = 1'b0;
        m_w_ready    = 1'b0;
        model_last_d = 1'b1;
        model_spur   = 1'b0;
        model_tmo    = 1'b0;
        raise(0, 64'h8000_3000, 64'h0, 8'h0);
        serve("rmg_if", 0, 64'h8000_3000, 64'h0, 8'h0, 64'h5A5A, 1, 1'b0, 0, exp_of(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
